// File: rtl/uart_globals_pkg.sv
// Shared UART transfer-configuration encodings plus the Tx serializer state type.
// Helper functions decode the character length and clamp the oversampling factor.
package uart_globals_pkg;

    localparam int CHAR_LENGTH = 8;

    typedef enum logic [1:0] {
        STOP_ONE_HALF = 2'd0,
        STOP_ONE      = 2'd1,
        STOP_TWO      = 2'd2
    } stop_bit_e;

    typedef enum logic [3:0] {
        UART_NONE = 4'd0,
        UART_5BIT = 4'd5,
        UART_6BIT = 4'd6,
        UART_7BIT = 4'd7,
        UART_8BIT = 4'd8
    } uart_type_e;

    typedef enum logic [3:0] {
        OS_2 = 4'd2,
        OS_4 = 4'd4,
        OS_6 = 4'd6,
        OS_8 = 4'd8
    } oversampling_e;

    typedef enum logic {PARITY_EVEN = 1'b0, PARITY_ODD = 1'b1} parity_e;

    typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} shift_direction_e;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

    // Number of data bits for a uart_type encoding; 0 means "no transfer".
    function automatic logic [3:0] char_bits(input logic [3:0] uart_type);
        case (uart_type)
            UART_5BIT, UART_6BIT, UART_7BIT, UART_8BIT: return uart_type;
            default:                                    return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] os_factor(input logic [3:0] os);
        case (os)
            OS_2, OS_4, OS_6, OS_8: return os;
            default:                return OS_2;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Loadable down-counter for bit timing: counts len-1..0 after a load; tick_end marks the
// last cycle of the loaded period and tick_pre_end the cycle before it.
module uart_baud_tick_gen #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         tick_end,
    output logic         tick_pre_end
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        count_d = count_q;
        if (load) begin
            count_d = len - W'(1);
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_end     = (count_q == '0);
    assign tick_pre_end = (count_q == W'(1));

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 5-8 data bits, optional parity, 1/1.5/2 stop bits.
// Define UART_TX_PARITY_EN to include the parity bit; the default build has no parity.
module uart_tx_serializer #(
    parameter int DIV_W       = 16,
    parameter int CHAR_LENGTH = uart_globals_pkg::CHAR_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIV_W-1:0]       cfg_baud_div,
    input  logic [3:0]             cfg_oversampling,
    input  logic [3:0]             cfg_uart_type,
    input  logic [1:0]             cfg_stop_bit,
    input  logic                   cfg_msb_first,
    input  logic                   cfg_parity,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [CHAR_LENGTH-1:0] s_data,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done
);

    import uart_globals_pkg::*;

    localparam int PW = DIV_W + 5;  // holds 2 * div * 8
    localparam int IW = $clog2(CHAR_LENGTH);

    uart_tx_state_e         state_q, state_d;
    logic [CHAR_LENGTH-1:0] data_q, data_d;
    logic [3:0]             nbits_q, nbits_d;
    logic                   msb_first_q, msb_first_d;
    logic [1:0]             stop_q, stop_d;
    logic [PW-1:0]          period_q, period_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   s_ready_q, s_ready_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    logic [DIV_W-1:0] div_eff;
    logic [PW-1:0]    period_in, stop_len, tick_len;
    logic [3:0]       nbits_in;
    logic [IW-1:0]    next_idx;
    logic             tick_load, tick_end, tick_pre_end;

    function automatic logic bit_at(input logic [CHAR_LENGTH-1:0] data, input logic [3:0] nbits,
                                    input logic msb_first, input logic [IW-1:0] idx);
        logic [IW-1:0] last;
        last = IW'(nbits - 4'd1);
        return msb_first ? data[last - idx] : data[idx];
    endfunction

    always_comb begin
        div_eff   = (cfg_baud_div == '0) ? DIV_W'(1) : cfg_baud_div;
        period_in = PW'(div_eff) * PW'(os_factor(cfg_oversampling));
        nbits_in  = char_bits(cfg_uart_type);
        case (stop_q)
            STOP_TWO:      stop_len = period_q << 1;
            STOP_ONE_HALF: stop_len = period_q + (period_q >> 1);
            default:       stop_len = period_q;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    logic parity_odd_q, parity_odd_d;
    logic parity_bit;

    always_comb begin
        parity_bit = parity_odd_q;
        for (int i = 0; i < CHAR_LENGTH; i++) begin
            if (4'(i) < nbits_q) parity_bit = parity_bit ^ data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) parity_odd_q <= 1'b0;
        else     parity_odd_q <= parity_odd_d;
    end
`else
    logic unused_cfg_parity;
    assign unused_cfg_parity = cfg_parity;
`endif

    // Outputs are registered from the next state, so tx changes in the cycle after a decision.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        nbits_d      = nbits_q;
        msb_first_d  = msb_first_q;
        stop_d       = stop_q;
        period_d     = period_q;
        bit_idx_d    = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_odd_d = parity_odd_q;
`endif
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        tick_load    = 1'b0;
        tick_len     = period_q;
        next_idx     = bit_idx_q + IW'(1);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // An unsupported character length consumes the character without a frame.
                if (s_valid && s_ready_q && nbits_in != 4'd0) begin
                    data_d       = s_data;
                    nbits_d      = nbits_in;
                    msb_first_d  = cfg_msb_first;
                    stop_d       = cfg_stop_bit;
                    period_d     = period_in;
`ifdef UART_TX_PARITY_EN
                    parity_odd_d = cfg_parity;
`endif
                    bit_idx_d    = '0;
                    tick_load    = 1'b1;
                    tick_len     = period_in;
                    tx_d         = 1'b0;
                    state_d      = START;
                end
            end
            START: begin
                if (tick_end) begin
                    state_d   = DATA;
                    tick_load = 1'b1;
                    tx_d      = bit_at(data_q, nbits_q, msb_first_q, IW'(0));
                end
            end
            DATA: begin
                if (tick_end) begin
                    tick_load = 1'b1;
                    if (bit_idx_q == IW'(nbits_q - 4'd1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        tx_d     = parity_bit;
`else
                        state_d  = STOP;
                        tx_d     = 1'b1;
                        tick_len = stop_len;
`endif
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = bit_at(data_q, nbits_q, msb_first_q, next_idx);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_end) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    tick_load = 1'b1;
                    tick_len  = stop_len;
                end
            end
`endif
            STOP: begin
                frame_done_d = tick_pre_end;
                if (tick_end) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        s_ready_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            nbits_q      <= '0;
            msb_first_q  <= 1'b0;
            stop_q       <= '0;
            period_q     <= '0;
            bit_idx_q    <= '0;
            tx_q         <= 1'b1;
            s_ready_q    <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            nbits_q      <= nbits_d;
            msb_first_q  <= msb_first_d;
            stop_q       <= stop_d;
            period_q     <= period_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    uart_baud_tick_gen #(.W(PW)) u_tick (
        .clk          (clk),
        .rst          (rst),
        .load         (tick_load),
        .len          (tick_len),
        .tick_end     (tick_end),
        .tick_pre_end (tick_pre_end)
    );

    assign tx         = tx_q;
    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a table of frame configurations with hand-computed
// bit sequences and lengths, plus hand-written back-to-back, reset and no-transfer sequences.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [15:0] div;
        logic [3:0]  os;
        logic [3:0]  typ;
        logic [1:0]  stop;
        logic        msb;
        logic        par;
        logic [7:0]  data;
        int          p;         // expected bit period
        int          n;         // data bits
        logic [7:0]  seq;       // seq[j] = j-th transmitted data bit
        logic        epar;      // expected parity bit
        int          stop_cyc;  // expected stop-bit cycles
        int          len_np;    // expected frame length without parity
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_baud_div = 16'd1;
    logic [3:0]  cfg_oversampling = 4'd2;
    logic [3:0]  cfg_uart_type = 4'd8;
    logic [1:0]  cfg_stop_bit = 2'd1;
    logic        cfg_msb_first = 1'b0;
    logic        cfg_parity = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, tx, busy, frame_done;

    int checks = 0;
    int errors = 0;
    vec_t vecs[10];
    logic tx_w[0:399];
    logic busy_w[0:399];
    logic fd_w[0:399];
    logic rdy_w[0:399];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DIV_W(16), .CHAR_LENGTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_baud_div     (cfg_baud_div),
        .cfg_oversampling (cfg_oversampling),
        .cfg_uart_type    (cfg_uart_type),
        .cfg_stop_bit     (cfg_stop_bit),
        .cfg_msb_first    (cfg_msb_first),
        .cfg_parity       (cfg_parity),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .tx               (tx),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Called at the negedge of the first cycle after a handshake (k = 1).
    task automatic capture(input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            tx_w[k]   = tx;
            busy_w[k] = busy;
            fd_w[k]   = frame_done;
            rdy_w[k]  = s_ready;
            @(negedge clk);
        end
    endtask

    // Reports 2 if tx was not constant over [lo,hi], otherwise the constant value.
    task automatic seg_check(input string name, input int lo, input int hi, input logic e);
        logic [1:0] val;
        val = {1'b0, tx_w[lo]};
        for (int k = lo; k <= hi; k++) if (tx_w[k] !== tx_w[lo]) val = 2'b10;
        check(name, 32'(val), {31'd0, e});
    endtask

    task automatic apply_cfg(input vec_t v);
        cfg_baud_div     = v.div;
        cfg_oversampling = v.os;
        cfg_uart_type    = v.typ;
        cfg_stop_bit     = v.stop;
        cfg_msb_first    = v.msb;
        cfg_parity       = v.par;
        s_data           = v.data;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   len, w, nbusy, nfd, stop_lo;
        v = vecs[i];
        len = v.len_np + PB * v.p;
        w = 0;
        while (s_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("v%0d_ready", i), 32'(s_ready), 32'd1);
        apply_cfg(v);
        s_valid = 1'b1;
        @(negedge clk);
        // Scramble inputs mid-frame: the latched character and configuration must be used.
        s_valid          = 1'b0;
        s_data           = ~v.data;
        cfg_baud_div     = 16'd9;
        cfg_oversampling = 4'd8;
        cfg_uart_type    = 4'd5;
        cfg_stop_bit     = 2'd2;
        cfg_msb_first    = ~v.msb;
        cfg_parity       = ~v.par;
        capture(len + 3);

        seg_check($sformatf("v%0d_start", i), 1, v.p, 1'b0);
        for (int j = 0; j < v.n; j++)
            seg_check($sformatf("v%0d_bit%0d", i, j), 1 + v.p * (1 + j), v.p * (2 + j), v.seq[j]);
        if (PB == 1)
            seg_check($sformatf("v%0d_parity", i), 1 + v.p * (1 + v.n), v.p * (2 + v.n), v.epar);
        stop_lo = v.p * (1 + v.n + PB) + 1;
        seg_check($sformatf("v%0d_stop", i), stop_lo, len, 1'b1);
        check($sformatf("v%0d_stop_len", i), 32'(len - stop_lo + 1), 32'(v.stop_cyc));

        nbusy = 0;
        nfd = 0;
        for (int k = 1; k <= len + 3; k++) begin
            if (busy_w[k] === 1'b1) nbusy++;
            if (fd_w[k] === 1'b1) nfd++;
        end
        check($sformatf("v%0d_busy_cycles", i), 32'(nbusy), 32'(len));
        check($sformatf("v%0d_done_at_end", i), 32'(fd_w[len]), 32'd1);
        check($sformatf("v%0d_done_count", i), 32'(nfd), 32'd1);
        check($sformatf("v%0d_ready_in_frame", i), 32'(rdy_w[1]), 32'd0);
        check($sformatf("v%0d_idle_tx", i), 32'(tx_w[len + 1]), 32'd1);
        check($sformatf("v%0d_idle_ready", i), 32'(rdy_w[len + 1]), 32'd1);
    endtask

    initial begin
        //             div     os    typ   stop  msb   par   data   p   n  seq    epar  stop len
        vecs[0] = '{16'd1, 4'd2, 4'd8, 2'd1, 1'b0, 1'b0, 8'h55,  2, 8, 8'h55, 1'b0,  2,  20};
        vecs[1] = '{16'd1, 4'd2, 4'd8, 2'd1, 1'b1, 1'b0, 8'h80,  2, 8, 8'h01, 1'b1,  2,  20};
        vecs[2] = '{16'd1, 4'd2, 4'd5, 2'd1, 1'b0, 1'b0, 8'hFF,  2, 5, 8'h1F, 1'b1,  2,  14};
        vecs[3] = '{16'd1, 4'd2, 4'd5, 2'd1, 1'b0, 1'b1, 8'hE0,  2, 5, 8'h00, 1'b1,  2,  14};
        vecs[4] = '{16'd1, 4'd4, 4'd7, 2'd0, 1'b0, 1'b0, 8'h07,  4, 7, 8'h07, 1'b1,  6,  38};
        vecs[5] = '{16'd1, 4'd4, 4'd7, 2'd0, 1'b0, 1'b1, 8'h07,  4, 7, 8'h07, 1'b0,  6,  38};
        vecs[6] = '{16'd3, 4'd8, 4'd6, 2'd2, 1'b0, 1'b0, 8'h2A, 24, 6, 8'h2A, 1'b1, 48, 216};
        vecs[7] = '{16'd0, 4'd2, 4'd6, 2'd1, 1'b1, 1'b1, 8'h2A,  2, 6, 8'h15, 1'b0,  2,  16};
        vecs[8] = '{16'd2, 4'd3, 4'd8, 2'd1, 1'b1, 1'b1, 8'hC5,  4, 8, 8'hA3, 1'b1,  4,  40};
        vecs[9] = '{16'd2, 4'd6, 4'd8, 2'd2, 1'b0, 1'b0, 8'h3C, 12, 8, 8'h3C, 1'b0, 24, 132};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tx", 32'(tx), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Back-to-back: s_valid held across two characters.
        @(negedge clk);
        apply_cfg(vecs[0]);
        s_valid = 1'b1;
        @(negedge clk);
        s_data = 8'h0F;
        for (int k = 1; k <= 60; k++) begin
            tx_w[k]  = tx;
            fd_w[k]  = frame_done;
            rdy_w[k] = s_ready;
            if (k == 22) s_valid = 1'b0;
            @(negedge clk);
        end
        begin
            int nfd;
            nfd = 0;
            for (int k = 1; k <= 60; k++) if (fd_w[k] === 1'b1) nfd++;
            check("b2b_done1", 32'(fd_w[20]), 32'd1);
            check("b2b_busy_ready", 32'(rdy_w[10]), 32'd0);
            check("b2b_gap_ready", 32'(rdy_w[21]), 32'd1);
            check("b2b_gap_tx", 32'(tx_w[21]), 32'd1);
            check("b2b_start2_a", 32'(tx_w[22]), 32'd0);
            check("b2b_start2_b", 32'(tx_w[23]), 32'd0);
            check("b2b_bit0", 32'(tx_w[24]), 32'd1);
            check("b2b_bit4", 32'(tx_w[32]), 32'd0);
            check("b2b_done2", 32'(fd_w[41]), 32'd1);
            check("b2b_done_count", 32'(nfd), 32'd2);
        end

        // Reset in the middle of the data bits.
        apply_cfg(vecs[0]);
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tx_w[k]   = tx;
            busy_w[k] = busy;
            fd_w[k]   = frame_done;
            rdy_w[k]  = s_ready;
            if (k == 6) rst = 1'b1;
            if (k == 7) rst = 1'b0;
            @(negedge clk);
        end
        begin
            int nlow, nfd;
            nlow = 0;
            nfd = 0;
            for (int k = 7; k <= 40; k++) if (tx_w[k] !== 1'b1) nlow++;
            for (int k = 1; k <= 40; k++) if (fd_w[k] === 1'b1) nfd++;
            check("rstmid_pre_ready", 32'(rdy_w[5]), 32'd0);
            check("rstmid_pre_tx", 32'(tx_w[6]), 32'd0);
            check("rstmid_tx", 32'(tx_w[7]), 32'd1);
            check("rstmid_ready", 32'(rdy_w[7]), 32'd1);
            check("rstmid_busy", 32'(busy_w[7]), 32'd0);
            check("rstmid_tx_stays_high", 32'(nlow), 32'd0);
            check("rstmid_no_done", 32'(nfd), 32'd0);
        end

        // uart_type = 0: handshake completes but no frame is sent.
        apply_cfg(vecs[0]);
        cfg_uart_type = 4'd0;
        s_valid = 1'b1;
        check("t0_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        check("t0_ready_after", 32'(s_ready), 32'd1);
        capture(25);
        begin
            int nlow, nfd, nbusy;
            nlow = 0;
            nfd = 0;
            nbusy = 0;
            for (int k = 1; k <= 25; k++) begin
                if (tx_w[k] !== 1'b1) nlow++;
                if (fd_w[k] === 1'b1) nfd++;
                if (busy_w[k] === 1'b1) nbusy++;
            end
            check("t0_tx_high", 32'(nlow), 32'd0);
            check("t0_no_done", 32'(nfd), 32'd0);
            check("t0_no_busy", 32'(nbusy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
